// File: rtl/updown_seq_ctrl.sv
// Sequencing controller for a 3-bit up/down counter.
// Drives the counter's mode (m) and toggle-enable (t) from its Q feedback.
// The count ping-pongs between LO and HI. The block also supports start, stop,
// single-step and an optional auto-stop after a number of reversals.
// The counter updates on the falling edge, so a t/m value registered at rising
// edge k takes effect before rising edge k+1. Decisions use only the q_in
// sampled at the current edge.

module updown_seq_ctrl #(
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned LO          = 1,
   parameter int unsigned HI          = 6,
   parameter int unsigned MAX_BOUNCES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic [WIDTH-1:0] q_in,
   output logic             m,
   output logic             t,
   output logic             busy,
   output logic             done,
   output logic [7:0]       bounce_cnt
);

   // Reject bound settings that would leave the window empty or out of range.
   if (LO >= HI) begin : gen_bad_bounds
      $error("updown_seq_ctrl: LO must be below HI");
   end
   if (HI > (2 ** WIDTH) - 1) begin : gen_bad_hi
      $error("updown_seq_ctrl: HI does not fit in WIDTH bits");
   end

   localparam logic [WIDTH-1:0] LoBound    = WIDTH'(LO);
   localparam logic [WIDTH-1:0] HiBound    = WIDTH'(HI);
   localparam logic [7:0]       MaxBounces = 8'(MAX_BOUNCES);
   // A limit above 255 can never be reached by the saturating counter.
   localparam bit               AutoStopEn = (MAX_BOUNCES != 0) && (MAX_BOUNCES <= 255);

   typedef enum logic [1:0] {
      StIdle,
      StUp,
      StDown,
      StStep
   } state_e;

   // Direction encoding matches the counter's mode input.
   localparam logic DirUp   = 1'b0;
   localparam logic DirDown = 1'b1;

   state_e     state_q, state_d;
   logic       dir_q, dir_d;
   logic       m_d, t_d, busy_d, done_d;
   logic [7:0] bounce_cnt_d;

   logic       at_hi, at_lo;
   logic [7:0] bounce_inc;
   logic       hit_limit;
   logic       reversal;
   logic       auto_stop;
   logic       clear_bounce;

   // Inclusive compares steer an out-of-window count back inside, never through a wrap.
   assign at_hi      = (q_in >= HiBound);
   assign at_lo      = (q_in <= LoBound);
   assign bounce_inc = (bounce_cnt == 8'hFF) ? 8'hFF : bounce_cnt + 8'd1;
   assign hit_limit  = AutoStopEn && (bounce_inc == MaxBounces);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. stop outranks start, and start outranks step.
   always_comb begin
      state_d      = state_q;
      reversal     = 1'b0;
      auto_stop    = 1'b0;
      clear_bounce = 1'b0;
      if (stop) begin
         // stop also overrides a reversal on the same edge: no bounce increment.
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  clear_bounce = 1'b1;
                  state_d      = at_hi ? StDown : StUp;
               end else if (step) begin
                  state_d = StStep;
               end
            end
            StUp: begin
               if (at_hi) begin
                  reversal = 1'b1;
                  if (hit_limit) begin
                     auto_stop = 1'b1;
                     state_d   = StIdle;
                  end else begin
                     state_d = StDown;
                  end
               end
            end
            StDown: begin
               if (at_lo) begin
                  reversal = 1'b1;
                  if (hit_limit) begin
                     auto_stop = 1'b1;
                     state_d   = StIdle;
                  end else begin
                     state_d = StUp;
                  end
               end
            end
            StStep: begin
               // A step is a single toggle cycle. Bounds are deliberately not checked.
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Output and direction next values, derived from the state being entered.
   always_comb begin
      dir_d = dir_q;
      unique case (state_d)
         StUp:    dir_d = DirUp;
         StDown:  dir_d = DirDown;
         default: dir_d = dir_q;
      endcase

      // Running states force m to their own direction. IDLE and STEP present the held dir.
      m_d    = dir_d;
      t_d    = (state_d != StIdle);
      busy_d = (state_d != StIdle);
      done_d = auto_stop;

      bounce_cnt_d = bounce_cnt;
      if (clear_bounce) begin
         bounce_cnt_d = 8'd0;
      end else if (reversal) begin
         bounce_cnt_d = bounce_inc;
      end
   end

   // Registered outputs, so the counter only ever sees glitch-free controls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dir_q      <= DirUp;
         m          <= 1'b0;
         t          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bounce_cnt <= 8'd0;
      end else begin
         dir_q      <= dir_d;
         m          <= m_d;
         t          <= t_d;
         busy       <= busy_d;
         done       <= done_d;
         bounce_cnt <= bounce_cnt_d;
      end
   end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl.
// Two instances share the control inputs: one never auto-stops, the other
// stops after 3 reversals. Each instance drives its own behavioural 3-bit
// up/down counter, which updates on the falling edge.

module tb_updown_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       step;

   logic [2:0] q0 = 3'd0;
   logic [2:0] q3 = 3'd0;
   logic       ld0, ld3;
   logic [2:0] ldv0, ldv3;

   logic       m0, t0, busy0, done0;
   logic [7:0] bc0;
   logic       m3, t3, busy3, done3;
   logic [7:0] bc3;

   int checks = 0;
   int errors = 0;

   updown_seq_ctrl #(
      .WIDTH       (3),
      .LO          (1),
      .HI          (6),
      .MAX_BOUNCES (0)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .step       (step),
      .q_in       (q0),
      .m          (m0),
      .t          (t0),
      .busy       (busy0),
      .done       (done0),
      .bounce_cnt (bc0)
   );

   updown_seq_ctrl #(
      .WIDTH       (3),
      .LO          (1),
      .HI          (6),
      .MAX_BOUNCES (3)
   ) dut3 (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .step       (step),
      .q_in       (q3),
      .m          (m3),
      .t          (t3),
      .busy       (busy3),
      .done       (done3),
      .bounce_cnt (bc3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter models: count on the falling edge when t=1; m=1 counts down.
   always @(negedge clk) begin
      if (ld0)     q0 <= ldv0;
      else if (t0) q0 <= m0 ? q0 - 3'd1 : q0 + 3'd1;
   end

   always @(negedge clk) begin
      if (ld3)     q3 <= ldv3;
      else if (t3) q3 <= m3 ? q3 - 3'd1 : q3 + 3'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [2:0] v0, input logic [2:0] v3);
      ld0  = 1'b1;
      ld3  = 1'b1;
      ldv0 = v0;
      ldv3 = v3;
      @(negedge clk);
      #1;
      ld0 = 1'b0;
      ld3 = 1'b0;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      step  = 1'b0;
      ld0   = 1'b0;
      ld3   = 1'b0;
      ldv0  = 3'd0;
      ldv3  = 3'd0;

      // Reset state
      preload(3'd0, 3'd0);
      tick();
      tick();
      chk1("rst_m", m0, 1'b0);
      chk1("rst_t", t0, 1'b0);
      chk1("rst_busy", busy0, 1'b0);
      chk1("rst_done", done0, 1'b0);
      chk8("rst_bounce", bc0, 8'd0);
      chk1("rst_t3", t3, 1'b0);

      // Full ping-pong cycle from 0
      rst   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("start_t", t0, 1'b1);
      chk1("start_m", m0, 1'b0);
      chk1("start_busy", busy0, 1'b1);
      chk3("start_q", q0, 3'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk3("up_q", q0, 3'(i));
         chk1("up_m", m0, 1'b0);
      end
      tick();
      chk3("hi_q", q0, 3'd6);
      chk1("hi_m", m0, 1'b1);
      chk8("hi_bounce", bc0, 8'd1);
      for (int i = 5; i >= 2; i--) begin
         tick();
         chk3("down_q", q0, 3'(i));
         chk1("down_m", m0, 1'b1);
      end
      tick();
      chk3("lo_q", q0, 3'd1);
      chk1("lo_m", m0, 1'b0);
      chk1("lo_t", t0, 1'b1);
      chk8("lo_bounce", bc0, 8'd2);
      chk1("lo_done", done0, 1'b0);

      // Stop mid-run at 4 going up, then restart
      tick();
      tick();
      chk3("pre_stop_q", q0, 3'd3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk1("stop_t", t0, 1'b0);
      chk1("stop_busy", busy0, 1'b0);
      chk3("stop_q", q0, 3'd4);
      tick();
      chk3("stop_hold_q", q0, 3'd4);
      chk8("stop_bounce_kept", bc0, 8'd2);
      chk1("stop_no_done", done0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("restart_t", t0, 1'b1);
      chk1("restart_m", m0, 1'b0);
      chk8("restart_bounce", bc0, 8'd0);
      tick();
      chk3("restart_q", q0, 3'd5);

      // Reverse at 6, stop at 3 while going down, then step once down
      tick();
      chk1("rev2_m", m0, 1'b1);
      tick();
      tick();
      chk3("pre_stop2_q", q0, 3'd4);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk1("stop2_t", t0, 1'b0);
      chk1("idle_m_dir_down", m0, 1'b1);
      chk3("stop2_q", q0, 3'd3);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk1("step_t", t0, 1'b1);
      chk1("step_m", m0, 1'b1);
      chk1("step_busy", busy0, 1'b1);
      tick();
      chk3("step_q", q0, 3'd2);
      chk1("step_end_t", t0, 1'b0);
      chk1("step_end_busy", busy0, 1'b0);
      tick();
      chk3("step_hold_q", q0, 3'd2);

      // Step up from 7 wraps to 0
      rst = 1'b0;
      tick();
      rst = 1'b1;
      preload(3'd7, 3'd0);
      chk1("idle_m_dir_up", m0, 1'b0);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk1("wrap_step_t", t0, 1'b1);
      chk1("wrap_step_m", m0, 1'b0);
      tick();
      chk3("wrap_q", q0, 3'd0);
      chk1("wrap_end_t", t0, 1'b0);

      // Start above HI goes down immediately
      preload(3'd7, 3'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("above_m", m0, 1'b1);
      chk1("above_t", t0, 1'b1);
      tick();
      chk3("above_q6", q0, 3'd6);
      tick();
      chk3("above_q5", q0, 3'd5);
      chk1("above_m2", m0, 1'b1);

      // Start and stop on the same edge
      stop = 1'b1;
      tick();
      chk1("stop3_t", t0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk1("ss_t", t0, 1'b0);
      chk1("ss_busy", busy0, 1'b0);
      tick();
      chk3("ss_hold_q", q0, 3'd4);

      // Reset during a run
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk1("prerst_m", m0, 1'b1);
      chk8("prerst_bounce", bc0, 8'd1);
      rst = 1'b0;
      tick();
      chk1("midrst_m", m0, 1'b0);
      chk1("midrst_t", t0, 1'b0);
      chk1("midrst_busy", busy0, 1'b0);
      chk8("midrst_bounce", bc0, 8'd0);
      chk1("midrst_done", done0, 1'b0);
      rst = 1'b1;

      // Auto-stop after three reversals
      preload(3'd0, 3'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("as_start_t", t3, 1'b1);
      chk1("as_start_m", m3, 1'b0);
      repeat (5) tick();
      chk3("as_rev1_q", q3, 3'd6);
      chk1("as_rev1_m", m3, 1'b1);
      chk8("as_rev1_bounce", bc3, 8'd1);
      repeat (5) tick();
      chk3("as_rev2_q", q3, 3'd1);
      chk1("as_rev2_m", m3, 1'b0);
      chk8("as_rev2_bounce", bc3, 8'd2);
      repeat (4) tick();
      chk3("as_pre_q", q3, 3'd5);
      chk1("as_pre_done", done3, 1'b0);
      chk1("as_pre_t", t3, 1'b1);
      tick();
      chk3("as_q", q3, 3'd6);
      chk1("as_done", done3, 1'b1);
      chk1("as_t", t3, 1'b0);
      chk1("as_busy", busy3, 1'b0);
      chk8("as_bounce", bc3, 8'd3);
      chk1("as_m_dir_up", m3, 1'b0);
      tick();
      chk1("as_done_pulse", done3, 1'b0);
      chk3("as_hold_q", q3, 3'd6);
      tick();
      chk3("as_hold_q2", q3, 3'd6);
      chk8("as_bounce_kept", bc3, 8'd3);
      chk1("unlimited_no_done", done0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_seq_ctrl.md
Name: updown_seq_ctrl

Overview:
Sequencing controller that sits directly upstream of the 3-bit synchronous up/down counter. It drives the counter's mode (M) and toggle-enable (T) inputs. It takes the counter's Q back as feedback so the count ping-pongs between programmable bounds. It also supports start, stop, single-step and a bounded number of direction reversals, with a done pulse.

Parameters:
WIDTH, 3, width of the counter feedback bus
LO, 1, lower turn-around bound (0 <= LO < HI)
HI, 6, upper turn-around bound (HI <= 2**WIDTH-1)
MAX_BOUNCES, 0, reversals before auto-stop; 0 means run until stop

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  level-sampled request to begin continuous run
stop  input  1  level-sampled request to halt
step  input  1  request for exactly one count in the current direction (IDLE only)
q_in  input  WIDTH  counter Q feedback
m  output  1  counter mode: 0 = up, 1 = down
t  output  1  counter toggle-enable: 1 = count at the counter's next active edge
busy  output  1  high in UP, DOWN or STEP
done  output  1  one-cycle pulse on auto-stop after MAX_BOUNCES reversals
bounce_cnt  output  8  reversals since the last start; saturates at 255

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, m=0, t=0, busy=0, done=0, bounce_cnt=0, dir=up. The counter has its own reset and is not cleared by this block.
- All outputs are registered and change only on the rising edge of clk.
- Timing: the counter updates on the falling edge. A t/m value set at rising edge k acts at falling edge k, and the result appears on q_in at rising edge k+1. Decisions are made on the q_in sampled at the current edge; no look-ahead is used.
- States: IDLE, UP, DOWN, STEP.
- Input priority per edge: stop > start > step.
- IDLE: t=0, m=dir.
  - start: go to UP if q_in < HI, otherwise DOWN. Clear bounce_cnt.
  - step (no start): go to STEP.
- UP: t=1, m=0, dir=up.
  - If q_in >= HI: go to DOWN, m=1, bounce_cnt+1.
  - So count HI-1 → HI is followed by HI → HI-1 with no dwell.
- DOWN: t=1, m=1, dir=down.
  - If q_in <= LO: go to UP, m=0, bounce_cnt+1.
- STEP: t=1 for exactly one cycle with m=dir, then IDLE with t=0.
  - Bounds are not checked; stepping past HI or LO, or wrapping 7→0, is allowed.
- Auto-stop: MAX_BOUNCES != 0 and a reversal makes bounce_cnt reach MAX_BOUNCES.
  - Go to IDLE instead of reversing: t=0, done=1 for one cycle.
  - dir keeps the last run direction.
- stop in any state: next edge gives IDLE, t=0. Counter holds its value. bounce_cnt is retained until the next start. No done pulse.
- start while already in UP/DOWN: ignored.
- step outside IDLE: ignored.
- Out-of-range q_in at start or mid-run (e.g. 7 with HI=6): the >=/<= compares steer the count back toward the window. Never wraps while running.
- Reset asserted mid-run: IDLE on that edge, t=0. Any in-flight count at the following falling edge is not suppressed beyond t=0.
- Simultaneous reversal and stop: stop wins; bounce_cnt is not incremented.

Test Plan:
- Reset, counter at 0, pulse start → t=1, m=0. q_in runs 0,1,…,6, then m=1 in the cycle q_in=6 is seen. Then 5,4,3,2,1; m=0 at q_in=1; bounce_cnt=2 after one full cycle.
- MAX_BOUNCES=3, start from q_in=1 → reversals at 6, 1, 6. At the third reversal t=0, done=1 for one cycle, bounce_cnt=3, q_in holds at 6.
- Mid-run at q_in=4 going up, assert stop → t=0 next edge, q_in stays 4. Assert start → resumes up from 4, bounce_cnt=0.
- IDLE, dir=down, q_in=3, pulse step → exactly one cycle of t=1, m=1; q_in=2; back to IDLE. Step with dir=up at q_in=7 → q_in wraps to 0.
- Preload counter to 7 (above HI=6), pulse start → DOWN chosen immediately, q_in 7→6→5; no wrap to 0.
- Start and stop on the same edge → stays IDLE, t=0. Assert rst=0 during UP → next edge m=0, t=0, busy=0, bounce_cnt=0.
